// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encodings and the
// device-window base addresses that the SoC top also uses.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  localparam logic [31:0] SERIAL_MMIO = 32'h1000_0000;
  localparam logic [31:0] RTC_MMIO    = 32'h2000_0000;

  // A single-master build still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Grant selection for the memory bus arbiter. BUS_ARB_RR_EN selects round-robin
// (search from ptr+1); otherwise fixed priority with the lowest index winning.
module rr_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
`ifdef BUS_ARB_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
`ifdef BUS_ARB_RR_EN
      cand = IDX_W'((int'(ptr) + 1 + k) % N);
`else
      cand = IDX_W'(k);
`endif
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master to single-port memory arbiter, one transaction at a time.
// Define BUS_ARB_RR_EN for round-robin grants; default is fixed priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MASK_W      = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*MASK_W-1:0] m_mask,
  output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [NUM_MASTERS-1:0]        m_skip,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [MASK_W-1:0]             mem_mask,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  // Handshake: a master holds m_req and payload until its one-cycle m_ready;
  // downstream, mem_req and mem_* hold steady through ISSUE until mem_ack.
  arb_state_e             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       grant_idx, win_idx;
  logic                   any_req, grant_fire, resp_live;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [MASK_W-1:0]      sel_mask;
  logic                   lat_we, lat_skip;
  logic [ADDR_W-1:0]      lat_addr;
  logic [DATA_W-1:0]      lat_wdata, lat_rdata;
  logic [MASK_W-1:0]      lat_mask;

  function automatic logic in_device_window(input logic [ADDR_W-1:0] a);
    return ((a & ~ADDR_W'(3)) == ADDR_W'(SERIAL_MMIO)) ||
           ((a & ~ADDR_W'(7)) == ADDR_W'(RTC_MMIO));
  endfunction

`ifdef BUS_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)             rr_ptr <= IDX_W'(NUM_MASTERS - 1);
    else if (grant_fire) rr_ptr <= grant_idx;
  end
`endif

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .req   (m_req),
`ifdef BUS_ARB_RR_EN
    .ptr   (rr_ptr),
`endif
    .grant (grant),
    .idx   (grant_idx)
  );

  assign any_req   = |grant;
  assign sel_we    = m_we[grant_idx];
  assign sel_addr  = m_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = m_wdata[grant_idx*DATA_W +: DATA_W];
  assign sel_mask  = m_mask[grant_idx*MASK_W +: MASK_W];

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          grant_fire = 1'b1;
          // A write that enables no byte lanes never touches memory.
          state_nxt  = (sel_we && sel_mask == '0) ? ARB_RESP : ARB_ISSUE;
        end
      end
      ARB_ISSUE: if (mem_ack) state_nxt = ARB_RESP;
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_idx   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mask  <= '0;
      lat_skip  <= 1'b0;
      lat_rdata <= '0;
    end else if (grant_fire) begin
      win_idx   <= grant_idx;
      lat_we    <= sel_we;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_mask  <= sel_mask;
      lat_skip  <= in_device_window(sel_addr);
      lat_rdata <= '0;
    end else if (state == ARB_ISSUE && mem_ack) begin
      lat_rdata <= lat_we ? '0 : mem_rdata;
    end
  end

  // Gating with rst keeps a response from escaping in the cycle reset lands.
  assign resp_live = (state == ARB_RESP) && !rst;

  always_comb begin
    m_ready = '0;
    m_skip  = '0;
    m_rdata = '0;
    if (resp_live) begin
      m_ready[win_idx]                   = 1'b1;
      m_skip[win_idx]                    = lat_skip;
      m_rdata[win_idx*DATA_W +: DATA_W]  = lat_rdata;
    end
  end

  assign mem_req   = (state == ARB_ISSUE);
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_mask  = lat_mask;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with two masters; expectations follow
// BUS_ARB_RR_EN when it is defined for the build.
module tb_mem_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*MW-1:0] m_mask;
  logic [NM*DW-1:0] m_rdata;
  logic [NM-1:0]    m_ready;
  logic [NM-1:0]    m_skip;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [MW-1:0]    mem_mask;
  logic [DW-1:0]    mem_rdata;
  logic             mem_ack;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_mask    (m_mask),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_skip    (m_skip),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [MW-1:0] mask);
    m_req[i]            = req;
    m_we[i]             = we;
    m_addr[i*AW +: AW]  = addr;
    m_wdata[i*DW +: DW] = wdata;
    m_mask[i*MW +: MW]  = mask;
  endtask

  task automatic idle_all();
    m_req   = '0;
    mem_ack = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL reset_m_ready: got %b want 00", m_ready); end
    checks++; if (m_skip !== 2'b00) begin errors++; $display("FAIL reset_m_skip: got %b want 00", m_skip); end
    checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL reset_m_rdata: got %h want 0", m_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (mem_mask !== 4'h0) begin errors++; $display("FAIL reset_mem_mask: got %h want 0", mem_mask); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    set_master(1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
    mem_rdata = 32'hDEAD_BEEF;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL read_c0_mem_req: got %b want 0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL read_c1_mem_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h8000_0010) begin errors++; $display("FAIL read_c1_mem_addr: got %h want 80000010", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL read_c1_mem_we: got %b want 0", mem_we); end
    mem_ack = 1'b1;
    step();
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL read_c2_m_ready: got %b want 10", m_ready); end
    checks++; if (m_rdata[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_c2_m_rdata: got %h want deadbeef", m_rdata[63:32]); end
    checks++; if (m_skip !== 2'b00) begin errors++; $display("FAIL read_c2_m_skip: got %b want 00", m_skip); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL read_c2_mem_req: got %b want 0", mem_req); end
    idle_all();
    step();
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL read_c3_m_ready: got %b want 00", m_ready); end
  endtask

  task automatic test_device_flag();
    int          mst [3] = '{1, 0, 0};
    logic        we  [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] adr [3] = '{32'h1000_0002, 32'h2000_0004, 32'h2000_0008};
    logic [31:0] wd  [3] = '{32'h00AB_0000, 32'h0, 32'h0};
    logic [3:0]  msk [3] = '{4'b0100, 4'hF, 4'hF};
    logic [31:0] rd  [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0BAD_F00D};
    logic        skp [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0]  exp_rdy, exp_skp;
    logic [31:0] exp_rd;
    for (int v = 0; v < 3; v++) begin
      set_master(mst[v], 1'b1, we[v], adr[v], wd[v], msk[v]);
      mem_rdata = rd[v];
      exp_rdy   = 2'(1 << mst[v]);
      exp_skp   = skp[v] ? exp_rdy : 2'b00;
      exp_rd    = we[v] ? 32'h0 : rd[v];
      step();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL dev%0d_mem_req: got %b want 1", v, mem_req); end
      checks++; if (mem_we !== we[v]) begin errors++; $display("FAIL dev%0d_mem_we: got %b want %b", v, mem_we, we[v]); end
      checks++; if (mem_addr !== adr[v]) begin errors++; $display("FAIL dev%0d_mem_addr: got %h want %h", v, mem_addr, adr[v]); end
      checks++; if (mem_mask !== msk[v]) begin errors++; $display("FAIL dev%0d_mem_mask: got %b want %b", v, mem_mask, msk[v]); end
      checks++; if (mem_wdata !== wd[v]) begin errors++; $display("FAIL dev%0d_mem_wdata: got %h want %h", v, mem_wdata, wd[v]); end
      mem_ack = 1'b1;
      step();
      checks++; if (m_ready !== exp_rdy) begin errors++; $display("FAIL dev%0d_m_ready: got %b want %b", v, m_ready, exp_rdy); end
      checks++; if (m_skip !== exp_skp) begin errors++; $display("FAIL dev%0d_m_skip: got %b want %b", v, m_skip, exp_skp); end
      checks++; if (m_rdata[mst[v]*DW +: DW] !== exp_rd) begin errors++; $display("FAIL dev%0d_m_rdata: got %h want %h", v, m_rdata[mst[v]*DW +: DW], exp_rd); end
      idle_all();
      step();
    end
  endtask

  task automatic test_zero_mask();
    set_master(0, 1'b1, 1'b1, 32'h8000_0040, 32'h5555_5555, 4'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zmask_c1_mem_req: got %b want 0", mem_req); end
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL zmask_c1_m_ready: got %b want 01", m_ready); end
    checks++; if (m_rdata[31:0] !== 32'h0) begin errors++; $display("FAIL zmask_c1_m_rdata: got %h want 0", m_rdata[31:0]); end
    idle_all();
    step();
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL zmask_c2_m_ready: got %b want 00", m_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zmask_c2_mem_req: got %b want 0", mem_req); end
    step();
  endtask

  task automatic test_contention();
    int         exp_m [4];
    logic [1:0] exp_rdy;
    bit         seen;
`ifdef BUS_ARB_RR_EN
    exp_m = '{0, 1, 0, 1};
`else
    exp_m = '{0, 0, 0, 0};
`endif
    set_master(0, 1'b1, 1'b0, 32'h8000_1000, 32'h0, 4'hF);
    set_master(1, 1'b1, 1'b0, 32'h8000_2000, 32'h0, 4'hF);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_00A5;
    for (int t = 0; t < 4; t++) begin
      seen    = 1'b0;
      exp_rdy = 2'(1 << exp_m[t]);
      for (int c = 0; c < 8 && !seen; c++) begin
        step();
        if (m_ready !== 2'b00) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL contend%0d_timeout: got none want %b", t, exp_rdy);
      end else if (m_ready !== exp_rdy) begin
        errors++; $display("FAIL contend%0d_grant: got %b want %b", t, m_ready, exp_rdy);
      end
    end
    idle_all();
    step();
    step();
  endtask

  task automatic test_stall();
    set_master(1, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'hF);
    mem_ack   = 1'b0;
    mem_rdata = 32'hCAFE_0001;
    step();
    set_master(0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
    for (int c = 1; c <= 5; c++) begin
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stall_c%0d_mem_req: got %b want 1", c, mem_req); end
      checks++; if (mem_addr !== 32'h8000_0200) begin errors++; $display("FAIL stall_c%0d_mem_addr: got %h want 80000200", c, mem_addr); end
      checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL stall_c%0d_m_ready: got %b want 00", c, m_ready); end
      if (c == 5) mem_ack = 1'b1;
      step();
    end
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL stall_resp_m_ready: got %b want 10", m_ready); end
    checks++; if (m_rdata[63:32] !== 32'hCAFE_0001) begin errors++; $display("FAIL stall_resp_m_rdata: got %h want cafe0001", m_rdata[63:32]); end
    mem_ack  = 1'b0;
    m_req[1] = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_idle_mem_req: got %b want 0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stall_next_mem_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h8000_0100) begin errors++; $display("FAIL stall_next_mem_addr: got %h want 80000100", mem_addr); end
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0002;
    step();
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL stall_next_m_ready: got %b want 01", m_ready); end
    checks++; if (m_rdata[31:0] !== 32'hCAFE_0002) begin errors++; $display("FAIL stall_next_m_rdata: got %h want cafe0002", m_rdata[31:0]); end
    idle_all();
    step();
  endtask

  task automatic test_reset_mid_issue();
    set_master(0, 1'b1, 1'b0, 32'h8000_0300, 32'h0, 4'hF);
    mem_ack   = 1'b0;
    mem_rdata = 32'h7777_7777;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_c1_mem_req: got %b want 1", mem_req); end
    rst = 1'b1;
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_c2_mem_req: got %b want 0", mem_req); end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL rstmid_c2_m_ready: got %b want 00", m_ready); end
    rst     = 1'b0;
    m_req   = '0;
    mem_ack = 1'b1;
    step();
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL rstmid_c3_m_ready: got %b want 00", m_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_c3_mem_req: got %b want 0", mem_req); end
    mem_ack = 1'b0;
    step();
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL rstmid_c4_m_ready: got %b want 00", m_ready); end
    set_master(1, 1'b1, 1'b0, 32'h8000_0400, 32'h0, 4'hF);
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_idle_mem_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h8000_0400) begin errors++; $display("FAIL rstmid_idle_mem_addr: got %h want 80000400", mem_addr); end
    mem_ack = 1'b1;
    step();
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL rstmid_after_m_ready: got %b want 10", m_ready); end
    idle_all();
    step();
  endtask

  // Sequence and final report
  initial begin
    rst       = 1'b1;
    m_req     = '0;
    m_we      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    m_mask    = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_single_read();
    test_device_flag();
    test_zero_mask();
    test_contention();
    test_stall();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
